// File: rtl/xbar_resp_router.sv
// xbar_resp_router: return-path partner of the crossbar request arbiter.
// Remembers, in issue order, which master each forwarded command came from,
// and steers the slave's in-order responses back to that master.
module xbar_resp_router #(
    parameter int N_MASTERS = 16,
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MASTERS-1:0]       cmd_grant,
    input  logic                       cmd_fire,
    output logic                       cmd_ready,
    input  logic                       s_rsp_valid,
    input  logic [DATA_W-1:0]          s_rsp_data,
    output logic                       s_rsp_ready,
    output logic [N_MASTERS-1:0]       m_rsp_valid,
    output logic [DATA_W-1:0]          m_rsp_data,
    input  logic [N_MASTERS-1:0]       m_rsp_ready,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             grant_onehot;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] head_idx;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bad_cmd;
    logic             unexpected_rsp;

    // Grant qualification: exactly one bit set, encoded to a master index.
    always_comb begin
        grant_onehot = (cmd_grant != '0) &&
                       ((cmd_grant & (cmd_grant - N_MASTERS'(1))) == '0);
        push_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (cmd_grant[i]) push_idx = IDX_W'(i);
        end
    end

    assign empty     = (count == '0);
    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign head_idx  = fifo_mem[rd_ptr];

    // Response steering: only the head master sees valid; the slave sees
    // that master's ready. With nothing tracked, responses are drained.
    always_comb begin
        m_rsp_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_rsp_valid[i] = !empty && s_rsp_valid && (head_idx == IDX_W'(i));
        end
        if (!rst_n)     s_rsp_ready = 1'b0;
        else if (empty) s_rsp_ready = 1'b1;
        else            s_rsp_ready = m_rsp_ready[head_idx];
    end

    assign m_rsp_data  = s_rsp_data;
    assign outstanding = count;

    assign push           = cmd_fire && cmd_ready && grant_onehot;
    assign pop            = s_rsp_valid && s_rsp_ready && !empty;
    assign bad_cmd        = cmd_fire && (!cmd_ready || !grant_onehot);
    assign unexpected_rsp = s_rsp_valid && empty;

    // Entry storage: written on push only, never reset.
    // NOTE: the FIFO array has no reset; pointers and count define validity,
    // and leaving the array out of reset lets it map to plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_idx;
    end

    // Pointer, occupancy and sticky error state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bad_cmd || unexpected_rsp) err <= 1'b1;
        end
    end

endmodule
